uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 16'd15, reset value of DIV register (clocks per bit minus 1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries (power of 2, used only with UART_TX_FIFO_EN).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port srst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port configure  input  1  register write strobe, one write per high cycle.
REQ-006 SHALL have port addr  input  32  register byte address, bits [7:0] decoded, others ignored.
REQ-007 SHALL have port data_in  input  32  register write data.
REQ-008 SHALL have port data_out  output  32  combinational read data for addr, unmapped addresses read 0.
REQ-009 SHALL have port tx  output  1  registered serial line, idle high.

Function
REQ-010 SHALL map 0x00 CTRL: bit0 tx_en, R/W.
REQ-011 SHALL map 0x04 STATUS: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow sticky; write data_in[3]=1 clears overflow; other bits RO.
REQ-012 SHALL map 0x08 DIV: bits[15:0] R/W.
REQ-013 SHALL map 0x0C TXDATA: write pushes data_in[7:0] into the buffer; reads 0.
REQ-014 SHALL drop a TXDATA write when buffer full and set overflow the same edge.
REQ-015 SHALL implement FSM IDLE -> START -> DATA -> STOP -> (START if tx_en and buffer non-empty, else IDLE).
REQ-016 SHALL leave IDLE only when tx_en=1 and buffer non-empty, popping one byte into a shift register on that edge.
REQ-017 SHALL drive tx low at the first edge after the byte is written when FSM is IDLE (one-cycle latency from write edge to start bit).
REQ-018 SHALL hold each bit (start, 8 data LSB-first, stop=1) for exactly DIV+1 clocks; frame = 10*(DIV+1) clocks, 8N1.
REQ-019 SHALL latch DIV at frame start; DIV writes mid-frame take effect on the next frame.
REQ-020 SHALL start a queued frame with no idle gap directly after the stop bit.
REQ-021 SHALL complete the current frame when tx_en is cleared mid-frame, then go IDLE, retaining buffered bytes.
REQ-022 SHALL accept a push to a full buffer on the same edge as a pop (net occupancy unchanged, no overflow).
REQ-023 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with a separate count for full/empty.
REQ-024 SHALL treat DIV=0 as one clock per bit.

Reset
REQ-025 SHALL on srst_n low, asynchronously: tx=1, FSM=IDLE, buffer empty, tx_en=0, overflow=0, DIV=DEFAULT_DIV, bit/baud counters=0.
REQ-026 SHALL abort any frame in progress on reset, tx returning high immediately, no partial-frame resume after release.
REQ-027 SHALL make data_out reflect reset register values while srst_n low (STATUS=0x4).

Configuration
REQ-028 SHALL with macro UART_TX_FIFO_EN defined, buffer = FIFO_DEPTH-entry FIFO.
REQ-029 SHALL with UART_TX_FIFO_EN undefined, buffer = single holding register (full after one push, emptied on pop); all other behaviour identical.

Verification
REQ-030 SHALL verify: reset, DIV=3, tx_en=1, write 0x0C=0x55 -> tx low one clock later, bits 1,0,1,0,1,0,1,0 each 4 clocks, stop high, busy=0 after 40 clocks.
REQ-031 SHALL verify: FIFO enabled, write 0x41,0x42,0x43,0x44 back-to-back -> four contiguous frames, no gap, full=1 after 4th write, empty=1 after last pop.
REQ-032 SHALL verify: FIFO full, 5th write 0x45 -> dropped, STATUS bit3=1; write 0x04=0x8 -> bit3=0.
REQ-033 SHALL verify: tx_en=0 with 2 bytes queued -> tx stays high; set tx_en=1 -> frames start next edge.
REQ-034 SHALL verify: DIV changed 3->7 mid-frame -> current frame at 4 clocks/bit, next at 8.
REQ-035 SHALL verify: srst_n pulsed low mid-data-bit -> tx=1 same time, STATUS=0x4, DIV=DEFAULT_DIV, no frame after release.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - register-mapped 8N1 UART transmitter; UART_TX_FIFO_EN selects a FIFO_DEPTH-entry TX FIFO over a single holding register
module uart_tx_ctrl #(
  parameter logic [15:0] DEFAULT_DIV = 16'd15,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        configure,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx
);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_DIV    = 8'h08;
  localparam logic [7:0] ADDR_TXDATA = 8'h0C;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [15:0] frame_div_q, frame_div_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic        tx_en_q;
  logic        ovf_q;
  logic [15:0] div_q;

  logic        buf_full;
  logic        buf_empty;
  logic        buf_pop;
  logic        buf_push;
  logic [7:0]  buf_head;

  logic        wr_ctrl;
  logic        wr_status;
  logic        wr_div;
  logic        wr_txdata;
  logic        bit_done;

  // Only the low address byte and low data half-word carry meaning.
  logic unused_bits;
  assign unused_bits = ^{addr[31:8], data_in[31:16]};

  assign wr_ctrl   = configure && (addr[7:0] == ADDR_CTRL);
  assign wr_status = configure && (addr[7:0] == ADDR_STATUS);
  assign wr_div    = configure && (addr[7:0] == ADDR_DIV);
  assign wr_txdata = configure && (addr[7:0] == ADDR_TXDATA);

  // A write to a full buffer still lands if the FSM frees a slot on the same edge.
  assign buf_push  = wr_txdata && (!buf_full || buf_pop);
  assign bit_done  = (baud_cnt_q == frame_div_q);
  assign tx        = tx_q;

  // Control/status registers; overflow is sticky until software clears it.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      tx_en_q <= 1'b0;
      ovf_q   <= 1'b0;
      div_q   <= DEFAULT_DIV;
    end else begin
      if (wr_ctrl) tx_en_q <= data_in[0];
      if (wr_div)  div_q   <= data_in[15:0];
      if (wr_txdata && buf_full && !buf_pop) begin
        ovf_q <= 1'b1;
      end else if (wr_status && data_in[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign buf_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign buf_empty = (count_q == '0);
  assign buf_head  = fifo_mem_q[rd_ptr_q];

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (buf_push) fifo_mem_q[wr_ptr_q] <= data_in[7:0];
  end

  // FIFO pointers wrap explicitly; occupancy lives in its own counter.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (buf_push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (buf_pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({buf_push, buf_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic [7:0] hold_q;
  logic       hold_valid_q;

  assign buf_full  = hold_valid_q;
  assign buf_empty = !hold_valid_q;
  assign buf_head  = hold_q;

  // Single holding register; a push wins over a same-edge pop so it stays full.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (buf_push) begin
      hold_q       <= data_in[7:0];
      hold_valid_q <= 1'b1;
    end else if (buf_pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  // Transmit FSM state; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      frame_div_q <= DEFAULT_DIV;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      frame_div_q <= frame_div_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
    end
  end

  // Next-state logic; tx is computed for the state being entered so the line is registered.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    frame_div_d = frame_div_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    buf_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_en_q && !buf_empty) begin
          buf_pop     = 1'b1;
          shift_d     = buf_head;
          frame_div_d = div_q;
          baud_cnt_d  = '0;
          state_d     = S_START;
          tx_d        = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_DATA;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (tx_en_q && !buf_empty) begin
            buf_pop     = 1'b1;
            shift_d     = buf_head;
            frame_div_d = div_q;
            state_d     = S_START;
            tx_d        = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Register read mux.
  always_comb begin
    data_out = '0;
    case (addr[7:0])
      ADDR_CTRL:   data_out = {31'd0, tx_en_q};
      ADDR_STATUS: data_out = {28'd0, ovf_q, buf_empty, buf_full, (state_q != S_IDLE)};
      ADDR_DIV:    data_out = {16'd0, div_q};
      default:     data_out = '0;
    endcase
  end

endmodule
